ps2_voice_alloc: RTL and testbench

- Polyphonic successor to the single-key keyboard state machine in the ePiano path.
- Consumes PS/2 scan-code bytes from ps2_keyboard and parses make/break/extended sequences.
- Tracks up to NUM_VOICES simultaneously held keys in an age-ordered voice table; its outputs feed per-voice get_data/tone generators and the display.

---
 rtl/ps2_voice_alloc.sv | 144 ++++++++++++++
 tb/tb_ps2_voice_alloc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_voice_alloc.sv
// Polyphonic PS/2 key tracker: parses make/break/extended scan-code sequences and keeps
// an age-ordered, compacted table of held keys (slot 0 oldest) for per-voice tone generators.
module ps2_voice_alloc #(
  parameter int unsigned NUM_VOICES   = 4,
  parameter int unsigned STEAL_OLDEST = 1,
  parameter int unsigned CW           = 3
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [7:0]              data,
  input  logic                    ready,
  output logic [8*NUM_VOICES-1:0] voice_code,
  output logic [NUM_VOICES-1:0]   voice_valid,
  output logic [CW-1:0]           active_count,
  output logic [7:0]              last_code,
  output logic                    key_event,
  output logic                    drop
);

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e                state_q, state_d;
  logic [7:0]            code_q [NUM_VOICES];
  logic [7:0]            code_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] valid_q, valid_d;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            last_q, last_d;
  logic                  event_q, event_d;
  logic                  drop_q, drop_d;

  logic                  do_make, do_break;
  logic                  hit;
  int                    hit_idx;

  // Scan-code parser: only plain (non-extended) make/break reach the table.
  always_comb begin
    state_d  = state_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    if (ready) begin
      case (state_q)
        StIdle: begin
          if (data == 8'hF0)                      state_d = StBrk;
          else if (data == 8'hE0)                 state_d = StExt;
          else if (data != 8'h00 && !data[7])     do_make = 1'b1;
        end
        StBrk: begin
          do_break = 1'b1;
          state_d  = StIdle;
        end
        StExt:   state_d = (data == 8'hF0) ? StExtBrk : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (valid_q[i] && code_q[i] == data) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end
  end

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    count_d = count_q;
    last_d  = last_q;
    event_d = 1'b0;
    drop_d  = 1'b0;
    if (do_make && !hit) begin
      if (count_q < CW'(NUM_VOICES)) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (CW'(i) == count_q) begin
            code_d[i]  = data;
            valid_d[i] = 1'b1;
          end
        end
        count_d = count_q + CW'(1);
        last_d  = data;
        event_d = 1'b1;
      end else if (STEAL_OLDEST != 0) begin
        // Evict slot 0 by aging everything down; the new key becomes the youngest.
        for (int i = 0; i < NUM_VOICES - 1; i++) code_d[i] = code_q[i+1];
        code_d[NUM_VOICES-1] = data;
        last_d  = data;
        event_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (do_break && hit) begin
      for (int i = 0; i < NUM_VOICES - 1; i++) begin
        if (i >= hit_idx) begin
          code_d[i]  = code_q[i+1];
          valid_d[i] = valid_q[i+1];
        end
      end
      code_d[NUM_VOICES-1]  = 8'h00;
      valid_d[NUM_VOICES-1] = 1'b0;
      count_d = count_q - CW'(1);
      // New youngest key sits at index count_q-2 after compaction.
      last_d = 8'h00;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (i + 2 == int'(count_q)) last_d = code_d[i];
      end
      event_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      for (int i = 0; i < NUM_VOICES; i++) code_q[i] <= 8'h00;
      valid_q <= '0;
      count_q <= '0;
      last_q  <= 8'h00;
      event_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      count_q <= count_d;
      last_q  <= last_d;
      event_q <= event_d;
      drop_q  <= drop_d;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_code[8*g +: 8] = code_q[g];
  end

  assign voice_valid  = valid_q;
  assign active_count = count_q;
  assign last_code    = last_q;
  assign key_event    = event_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_ps2_voice_alloc.sv
// Bench for ps2_voice_alloc: a stealing and a dropping instance share one byte stream and
// are compared against a queue-based model of the held-key list.
module tb_ps2_voice_alloc;

  localparam int NV = 4;
  localparam int CW = 3;

  logic          clk, clr, ready;
  logic [7:0]    data;
  logic [8*NV-1:0] vc0, vc1;
  logic [NV-1:0] vv0, vv1;
  logic [CW-1:0] ac0, ac1;
  logic [7:0]    lc0, lc1;
  logic          ke0, ke1, dr0, dr1;

  int total = 0;
  int bad   = 0;

  ps2_voice_alloc #(.NUM_VOICES(NV), .STEAL_OLDEST(1), .CW(CW)) u_steal (
    .clk(clk), .clr(clr), .data(data), .ready(ready),
    .voice_code(vc0), .voice_valid(vv0), .active_count(ac0), .last_code(lc0),
    .key_event(ke0), .drop(dr0)
  );

  ps2_voice_alloc #(.NUM_VOICES(NV), .STEAL_OLDEST(0), .CW(CW)) u_keep (
    .clk(clk), .clr(clr), .data(data), .ready(ready),
    .voice_code(vc1), .voice_valid(vv1), .active_count(ac1), .last_code(lc1),
    .key_event(ke1), .drop(dr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters observed on the DUTs, sampled mid-cycle.
  int cnt_ev0 = 0, cnt_dr0 = 0, cnt_ev1 = 0, cnt_dr1 = 0;
  always @(negedge clk) begin
    cnt_ev0 <= cnt_ev0 + int'(ke0);
    cnt_dr0 <= cnt_dr0 + int'(dr0);
    cnt_ev1 <= cnt_ev1 + int'(ke1);
    cnt_dr1 <= cnt_dr1 + int'(dr1);
  end

  // Reference model: held keys oldest-first in a queue per instance.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  int  pst = 0;
  bit  x_ev0, x_dr0, x_ev1, x_dr1;
  logic [7:0] keys [6] = '{8'h15, 8'h1C, 8'h1B, 8'h23, 8'h24, 8'h2D};

  function automatic logic [8*NV-1:0] exp_code(input int w);
    logic [8*NV-1:0] v = '0;
    if (w == 0) foreach (mq0[i]) v[8*i +: 8] = mq0[i];
    else        foreach (mq1[i]) v[8*i +: 8] = mq1[i];
    return v;
  endfunction

  function automatic logic [NV-1:0] exp_valid(input int w);
    logic [NV-1:0] v = '0;
    int n = (w == 0) ? mq0.size() : mq1.size();
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] exp_last(input int w);
    if (w == 0) return (mq0.size() != 0) ? mq0[$] : 8'h00;
    return (mq1.size() != 0) ? mq1[$] : 8'h00;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    bit mk = 0, br = 0;
    int k0 = -1, k1 = -1;
    x_ev0 = 0; x_dr0 = 0; x_ev1 = 0; x_dr1 = 0;
    case (pst)
      0: begin
        if (b == 8'hF0) pst = 1;
        else if (b == 8'hE0) pst = 2;
        else if (b != 8'h00 && b < 8'h80) mk = 1;
      end
      1: begin br = 1; pst = 0; end
      2: pst = (b == 8'hF0) ? 3 : 0;
      default: pst = 0;
    endcase
    foreach (mq0[i]) if (mq0[i] == b) k0 = i;
    foreach (mq1[i]) if (mq1[i] == b) k1 = i;
    if (mk) begin
      if (k0 < 0) begin
        if (mq0.size() == NV) void'(mq0.pop_front());
        mq0.push_back(b);
        x_ev0 = 1;
      end
      if (k1 < 0) begin
        if (mq1.size() < NV) begin mq1.push_back(b); x_ev1 = 1; end
        else x_dr1 = 1;
      end
    end else if (br) begin
      if (k0 >= 0) begin mq0.delete(k0); x_ev0 = 1; end
      if (k1 >= 0) begin mq1.delete(k1); x_ev1 = 1; end
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data  = b;
    ready = 1'b1;
    model_byte(b);
  endtask

  task automatic idle();
    @(negedge clk);
    ready = 1'b0;
    data  = 8'h00;
    x_ev0 = 0; x_dr0 = 0; x_ev1 = 0; x_dr1 = 0;
  endtask

  // Reset with a make byte on the bus to show clr wins.
  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1; ready = 1'b1; data = 8'h1C;
    @(negedge clk);
    clr = 1'b0; ready = 1'b0; data = 8'h00;
    mq0.delete(); mq1.delete(); pst = 0;
    x_ev0 = 0; x_dr0 = 0; x_ev1 = 0; x_dr1 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (vc0 !== '0) begin bad++; $display("FAIL reset_code got=%h exp=0", vc0); end
    total++; if (vv0 !== '0 || vv1 !== '0) begin bad++; $display("FAIL reset_valid got=%b/%b exp=0", vv0, vv1); end
    total++; if (ac0 !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ac0); end
    total++; if (lc0 !== 8'h00) begin bad++; $display("FAIL reset_last got=%h exp=00", lc0); end
    total++; if (ke0 !== 1'b0 || dr1 !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b/%b exp=0", ke0, dr1); end
  endtask

  task automatic test_alloc();
    int e0 = cnt_ev0;
    send(8'h1C); send(8'h1B); send(8'h23); idle();
    @(posedge clk); #1;
    total++; if (vc0 !== 32'h00231B1C || vc0 !== exp_code(0)) begin bad++; $display("FAIL alloc_code got=%h exp=00231b1c", vc0); end
    total++; if (ac0 !== 3'd3) begin bad++; $display("FAIL alloc_count got=%0d exp=3", ac0); end
    total++; if (lc0 !== 8'h23) begin bad++; $display("FAIL alloc_last got=%h exp=23", lc0); end
    total++; if (cnt_ev0 - e0 != 3) begin bad++; $display("FAIL alloc_events got=%0d exp=3", cnt_ev0 - e0); end
  endtask

  task automatic test_break();
    send(8'hF0); send(8'h1B); idle();
    @(posedge clk); #1;
    total++; if (vc0 !== 32'h0000231C) begin bad++; $display("FAIL break_code got=%h exp=0000231c", vc0); end
    total++; if (ac0 !== 3'd2 || vv0 !== 4'b0011) begin bad++; $display("FAIL break_count got=%0d/%b exp=2/0011", ac0, vv0); end
    total++; if (lc0 !== 8'h23) begin bad++; $display("FAIL break_last got=%h exp=23", lc0); end
    send(8'hF0); send(8'h23); idle();
    @(posedge clk); #1;
    total++; if (lc0 !== 8'h1C) begin bad++; $display("FAIL break_last2 got=%h exp=1c", lc0); end
    total++; if (ac0 !== 3'd1) begin bad++; $display("FAIL break_count2 got=%0d exp=1", ac0); end
  endtask

  task automatic test_full();
    int e0, e1, d1;
    do_reset();
    e0 = cnt_ev0; e1 = cnt_ev1; d1 = cnt_dr1;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); idle();
    @(posedge clk); #1;
    total++; if (vc0 !== 32'h2C2D241D) begin bad++; $display("FAIL steal_code got=%h exp=2c2d241d", vc0); end
    total++; if (ac0 !== 3'd4 || lc0 !== 8'h2C) begin bad++; $display("FAIL steal_count got=%0d/%h exp=4/2c", ac0, lc0); end
    total++; if (cnt_ev0 - e0 != 5) begin bad++; $display("FAIL steal_events got=%0d exp=5", cnt_ev0 - e0); end
    total++; if (vc1 !== 32'h2D241D15) begin bad++; $display("FAIL keep_code got=%h exp=2d241d15", vc1); end
    total++; if (cnt_dr1 - d1 != 1) begin bad++; $display("FAIL keep_drops got=%0d exp=1", cnt_dr1 - d1); end
    total++; if (cnt_ev1 - e1 != 4) begin bad++; $display("FAIL keep_events got=%0d exp=4", cnt_ev1 - e1); end
    total++; if (cnt_dr0 != 0) begin bad++; $display("FAIL steal_drops got=%0d exp=0", cnt_dr0); end
  endtask

  task automatic test_ignored();
    int e0;
    logic [7:0] seq [10] = '{8'h1C, 8'h1C, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h33};
    do_reset();
    e0 = cnt_ev0;
    foreach (seq[i]) send(seq[i]);
    idle();
    @(posedge clk); #1;
    total++; if (vc0 !== 32'h0000001C || vv0 !== 4'b0001) begin bad++; $display("FAIL ignore_code got=%h/%b exp=1c/0001", vc0, vv0); end
    total++; if (cnt_ev0 - e0 != 1) begin bad++; $display("FAIL ignore_events got=%0d exp=1", cnt_ev0 - e0); end
    total++; if (lc0 !== 8'h1C || ac0 !== 3'd1) begin bad++; $display("FAIL ignore_last got=%h/%0d exp=1c/1", lc0, ac0); end
  endtask

  task automatic test_reset_mid_break();
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h1C); idle();
    @(posedge clk); #1;
    total++; if (vc0 !== 32'h0000001C || ac0 !== 3'd1) begin bad++; $display("FAIL rstbrk_code got=%h/%0d exp=1c/1", vc0, ac0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4] = '{8'h1C, 8'hF0, 8'h1C, 8'h1B};
    bit         evx [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    foreach (seq[i]) begin
      send(seq[i]);
      @(posedge clk); #1;
      total++;
      if (ke0 !== evx[i] || ke0 !== x_ev0) begin
        bad++; $display("FAIL b2b_event cycle %0d got=%b exp=%b", i + 1, ke0, evx[i]);
      end
    end
    idle();
    @(posedge clk); #1;
    total++; if (vc0 !== 32'h0000001B || lc0 !== 8'h1B) begin bad++; $display("FAIL b2b_final got=%h/%h exp=1b/1b", vc0, lc0); end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] b;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      if (r < 3)       b = 8'hF0;
      else if (r == 3) b = 8'hE0;
      else if (r == 4) b = 8'h80 | 8'($urandom_range(0, 127));
      else if (r == 5) b = 8'h00;
      else             b = keys[$urandom_range(0, 5)];
      send(b);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        total++; if (ke0 !== x_ev0 || ke1 !== x_ev1) begin bad++; $display("FAIL rnd_event_pre %0d got=%b/%b exp=%b/%b", n, ke0, ke1, x_ev0, x_ev1); end
        idle();
      end
      @(posedge clk); #1;
      total++; if (vc0 !== exp_code(0)) begin bad++; $display("FAIL rnd_code0 %0d got=%h exp=%h", n, vc0, exp_code(0)); end
      total++; if (vv0 !== exp_valid(0)) begin bad++; $display("FAIL rnd_valid0 %0d got=%b exp=%b", n, vv0, exp_valid(0)); end
      total++; if (ac0 !== CW'(mq0.size())) begin bad++; $display("FAIL rnd_count0 %0d got=%0d exp=%0d", n, ac0, mq0.size()); end
      total++; if (lc0 !== exp_last(0)) begin bad++; $display("FAIL rnd_last0 %0d got=%h exp=%h", n, lc0, exp_last(0)); end
      total++; if (ke0 !== x_ev0 || dr0 !== x_dr0) begin bad++; $display("FAIL rnd_pulse0 %0d got=%b%b exp=%b%b", n, ke0, dr0, x_ev0, x_dr0); end
      total++; if (vc1 !== exp_code(1)) begin bad++; $display("FAIL rnd_code1 %0d got=%h exp=%h", n, vc1, exp_code(1)); end
      total++; if (vv1 !== exp_valid(1)) begin bad++; $display("FAIL rnd_valid1 %0d got=%b exp=%b", n, vv1, exp_valid(1)); end
      total++; if (ac1 !== CW'(mq1.size())) begin bad++; $display("FAIL rnd_count1 %0d got=%0d exp=%0d", n, ac1, mq1.size()); end
      total++; if (lc1 !== exp_last(1)) begin bad++; $display("FAIL rnd_last1 %0d got=%h exp=%h", n, lc1, exp_last(1)); end
      total++; if (ke1 !== x_ev1 || dr1 !== x_dr1) begin bad++; $display("FAIL rnd_pulse1 %0d got=%b%b exp=%b%b", n, ke1, dr1, x_ev1, x_dr1); end
    end
    idle();
  endtask

  initial begin
    clr = 1'b0; ready = 1'b0; data = 8'h00;
    test_reset();
    test_alloc();
    test_break();
    test_full();
    test_ignored();
    test_reset_mid_break();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
